// File: rtl/monopix2_pkg.sv
// Shared constants and types for the Monopix2 chip-side readout emulator.
package monopix2_pkg;

    localparam int unsigned WORD_WIDTH = 27;

    // Hit word layout: {col[5:0], row[8:0], TE[5:0], LE[5:0]}
    localparam int unsigned LE_LSB  = 0;
    localparam int unsigned TE_LSB  = 6;
    localparam int unsigned ROW_LSB = 12;
    localparam int unsigned COL_LSB = 21;

    localparam int unsigned SHIFT_LEN = 27;

    typedef enum logic {
        IDLE,
        SHIFT
    } ro_state_t;

endpackage

// File: rtl/mono_hit_fifo.sv
// Synchronous hit FIFO with occupancy count and first-word-fall-through read data.
module mono_hit_fifo #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned WORD_WIDTH = 27,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty
);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;
    logic [AW:0]           count_nxt;

    // A push while full is still accepted when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop    = rd_en && !empty;
        do_push   = wr_en && (!full || do_pop);
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/monopix2_ro_emulator.sv
// Monopix2 readout emulator: stores injected hits and serves them over Freeze/Read/TokOut/DataOut.
module monopix2_ro_emulator #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned WORD_WIDTH = monopix2_pkg::WORD_WIDTH
) (
    input  logic                  CLK40,
    input  logic                  BUS_RST,
    input  logic                  HIT_WRITE,
    input  logic [WORD_WIDTH-1:0] HIT_DATA,
    output logic                  HIT_FULL,
    input  logic                  Freeze,
    input  logic                  Read,
    output logic                  TokOut,
    output logic                  DataOut,
    output logic                  OVERFLOW,
    output logic                  READ_ERR
);
    import monopix2_pkg::*;

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned BCW = $clog2(SHIFT_LEN);

    ro_state_t             state;
    ro_state_t             state_nxt;
    logic                  frozen_q;
    logic                  read_q;
    logic                  read_rise;
    logic                  start;
    logic [CW-1:0]         frz_cnt;
    logic [CW-1:0]         frz_cnt_nxt;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [WORD_WIDTH-1:0] fifo_rd_data;
    logic [WORD_WIDTH-1:0] shift_q;
    logic [WORD_WIDTH-1:0] shift_nxt;
    logic [BCW-1:0]        bit_cnt;
    logic [BCW-1:0]        bit_cnt_nxt;
    logic                  data_nxt;
    logic                  tok_nxt;
    logic                  err_nxt;
    logic                  ovf_nxt;

    mono_hit_fifo #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clk     (CLK40),
        .rst     (BUS_RST),
        .wr_en   (HIT_WRITE),
        .wr_data (HIT_DATA),
        .rd_en   (start),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (HIT_FULL),
        .empty   (fifo_empty)
    );

    assign read_rise = Read && !read_q;
    assign start     = (state == IDLE) && read_rise && frozen_q && (frz_cnt != '0);

    always_ff @(posedge CLK40) begin
        if (BUS_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frz_cnt_nxt = frz_cnt;
        if (Freeze && !frozen_q) begin
            frz_cnt_nxt = fifo_count;
        end else if (!Freeze && frozen_q) begin
            frz_cnt_nxt = '0;
        end else if (start) begin
            frz_cnt_nxt = frz_cnt - CW'(1);
        end

        // Frozen TokOut tracks the post-pop snapshot so it drops with the last Read.
        tok_nxt = frozen_q ? (frz_cnt_nxt != '0) : !fifo_empty;
        err_nxt = read_rise && !start;
        ovf_nxt = OVERFLOW || (HIT_WRITE && HIT_FULL && !start);

        data_nxt    = 1'b0;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    data_nxt    = fifo_rd_data[WORD_WIDTH-1];
                    shift_nxt   = fifo_rd_data << 1;
                    bit_cnt_nxt = BCW'(SHIFT_LEN - 1);
                end
            end
            SHIFT: begin
                if (bit_cnt != '0) begin
                    data_nxt    = shift_q[WORD_WIDTH-1];
                    shift_nxt   = shift_q << 1;
                    bit_cnt_nxt = bit_cnt - BCW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (BUS_RST) begin
            frozen_q <= 1'b0;
            read_q   <= 1'b0;
            frz_cnt  <= '0;
            shift_q  <= '0;
            bit_cnt  <= '0;
            TokOut   <= 1'b0;
            DataOut  <= 1'b0;
            OVERFLOW <= 1'b0;
            READ_ERR <= 1'b0;
        end else begin
            frozen_q <= Freeze;
            read_q   <= Read;
            frz_cnt  <= frz_cnt_nxt;
            shift_q  <= shift_nxt;
            bit_cnt  <= bit_cnt_nxt;
            TokOut   <= tok_nxt;
            DataOut  <= data_nxt;
            OVERFLOW <= ovf_nxt;
            READ_ERR <= err_nxt;
        end
    end

endmodule

// File: tb/tb_monopix2_ro_emulator.sv
// Self-checking bench for monopix2_ro_emulator: queue-based protocol model plus directed scenarios.
module tb_monopix2_ro_emulator;

    localparam int DEPTH = 64;

    logic        CLK40 = 1'b0;
    logic        BUS_RST = 1'b1;
    logic        HIT_WRITE = 1'b0;
    logic [26:0] HIT_DATA = '0;
    logic        HIT_FULL;
    logic        Freeze = 1'b0;
    logic        Read = 1'b0;
    logic        TokOut;
    logic        DataOut;
    logic        OVERFLOW;
    logic        READ_ERR;

    int errors = 0;
    int checks = 0;

    monopix2_ro_emulator #(.DEPTH(DEPTH), .WORD_WIDTH(27)) dut (
        .CLK40     (CLK40),
        .BUS_RST   (BUS_RST),
        .HIT_WRITE (HIT_WRITE),
        .HIT_DATA  (HIT_DATA),
        .HIT_FULL  (HIT_FULL),
        .Freeze    (Freeze),
        .Read      (Read),
        .TokOut    (TokOut),
        .DataOut   (DataOut),
        .OVERFLOW  (OVERFLOW),
        .READ_ERR  (READ_ERR)
    );

    always #12.5 CLK40 = ~CLK40;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: hit queue, snapshot size, and a serial word scheduled by its accept cycle.
    logic [26:0] mq[$];
    int          cyc = 0;
    bit          mf = 0;
    bit          rd_prev = 0;
    int          snap = 0;
    bit          m_ov = 0;
    bit          e_tok = 0;
    bit          e_err = 0;
    bit          e_data = 0;
    int          last_m = -1000;
    logic [26:0] last_w = '0;
    bit          chk_en = 0;

    always @(posedge CLK40) begin : model
        int  sz_old;
        int  snap_new;
        bit  rise;
        bit  busy;
        bit  valid;
        int  d;
        cyc = cyc + 1;
        if (BUS_RST) begin
            mq.delete();
            mf = 0; rd_prev = 0; snap = 0; m_ov = 0;
            e_tok = 0; e_err = 0; last_m = -1000;
        end else begin
            sz_old = mq.size();
            rise   = Read && !rd_prev;
            busy   = (cyc - last_m >= 1) && (cyc - last_m <= 27);
            valid  = rise && !busy && mf && (snap > 0);
            e_err  = rise && !valid;
            snap_new = snap;
            if (Freeze && !mf) snap_new = sz_old;
            else if (!Freeze && mf) snap_new = 0;
            else if (valid) snap_new = snap - 1;
            if (valid) begin
                last_w = mq.pop_front();
                last_m = cyc;
            end
            if (HIT_WRITE) begin
                if (mq.size() < DEPTH) mq.push_back(HIT_DATA);
                else m_ov = 1;
            end
            e_tok   = mf ? (snap_new != 0) : (sz_old != 0);
            snap    = snap_new;
            mf      = Freeze;
            rd_prev = Read;
        end
        d = cyc - last_m;
        e_data = (d >= 0 && d <= 26) ? last_w[26 - d] : 1'b0;
        chk_en = 1;
    end

    always @(negedge CLK40) begin : compare
        if (chk_en) begin
            check("DataOut",  DataOut,  e_data);
            check("TokOut",   TokOut,   e_tok);
            check("READ_ERR", READ_ERR, e_err);
            check("OVERFLOW", OVERFLOW, m_ov);
            check("HIT_FULL", HIT_FULL, mq.size() == DEPTH);
            check("frz_cnt",  dut.frz_cnt, snap);
            check("fifo_cnt", dut.fifo_count, mq.size());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK40);
    endtask

    task automatic do_reset();
        BUS_RST = 1; Freeze = 0; Read = 0; HIT_WRITE = 0;
        idle(2);
        BUS_RST = 0;
        idle(1);
    endtask

    task automatic push(input logic [26:0] w);
        HIT_WRITE = 1; HIT_DATA = w;
        idle(1);
        HIT_WRITE = 0;
    endtask

    // Read edge followed by 27 captured bits; next Read edge lands 30 cycles after this one.
    task automatic read_word(output logic [26:0] w, output int errs, output logic tok0);
        Read = 1;
        idle(1);
        Read = 0;
        tok0 = TokOut;
        w = '0; errs = 0;
        for (int i = 0; i < 27; i++) begin
            w = {w[25:0], DataOut};
            errs += int'(READ_ERR);
            idle(1);
        end
        idle(2);
    endtask

    initial begin
        logic [26:0] w;
        logic [26:0] d;
        int          errs;
        int          err_total;
        logic        tok0;

        idle(3);
        check("rst_TokOut", TokOut, 0);
        check("rst_DataOut", DataOut, 0);
        check("rst_OVERFLOW", OVERFLOW, 0);
        check("rst_READ_ERR", READ_ERR, 0);
        check("rst_HIT_FULL", HIT_FULL, 0);
        BUS_RST = 0;
        idle(1);

        // Two words, frozen, read back 30 cycles apart
        push(27'h5A5A5A5);
        push(27'h1234567);
        idle(2);
        check("t1_tok_unfrozen", TokOut, 1);
        Freeze = 1;
        idle(2);
        check("t1_frz_cnt", dut.frz_cnt, 2);
        read_word(w, errs, tok0);
        check("t1_word0", w, 27'h5A5A5A5);
        check("t1_tok_after_rd0", tok0, 1);
        read_word(w, errs, tok0);
        check("t1_word1", w, 27'h1234567);
        check("t1_tok_after_rd1", tok0, 0);
        check("t1_err", errs, 0);

        // Snapshot excludes hits pushed while frozen
        do_reset();
        push(27'h0000001); push(27'h2AAAAAA); push(27'h7000003);
        idle(2);
        Freeze = 1;
        idle(1);
        push(27'h0BEEF01); push(27'h0BEEF02);
        idle(2);
        check("t2_frz_cnt", dut.frz_cnt, 3);
        err_total = 0;
        read_word(w, errs, tok0); err_total += errs; check("t2_word0", w, 27'h0000001);
        read_word(w, errs, tok0); err_total += errs; check("t2_word1", w, 27'h2AAAAAA);
        read_word(w, errs, tok0); err_total += errs; check("t2_word2", w, 27'h7000003);
        check("t2_tok_last", tok0, 0);
        read_word(w, errs, tok0); err_total += errs; check("t2_word3", w, 0);
        check("t2_read_errs", err_total, 1);
        Freeze = 0;
        idle(4);
        check("t2_tok_released", TokOut, 1);
        check("t2_count", dut.fifo_count, 2);

        // Fill, overflow, push+pop while full, Read mid-shift
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            d = 27'h5000000 + 27'(i * 'h1111);
            push(d);
        end
        push(27'h7FFFFFF);
        idle(1);
        check("t3_full", HIT_FULL, 1);
        check("t3_overflow", OVERFLOW, 1);
        check("t3_count_full", dut.fifo_count, 64);
        Freeze = 1;
        idle(2);
        Read = 1; HIT_WRITE = 1; HIT_DATA = 27'h7ABCDEF;
        idle(1);
        Read = 0; HIT_WRITE = 0;
        check("t3_pushpop_count", dut.fifo_count, 64);
        w = '0; errs = 0;
        for (int i = 0; i < 27; i++) begin
            w = {w[25:0], DataOut};
            errs += int'(READ_ERR);
            if (i == 9) Read = 1;
            if (i == 10) Read = 0;
            idle(1);
        end
        check("t4_word_intact", w, 27'h5000000);
        check("t4_midshift_err", errs, 1);
        check("t4_frz_cnt", dut.frz_cnt, 63);
        check("t4_data_idle", DataOut, 0);

        // Reset in the middle of a shift
        Read = 1;
        idle(1);
        Read = 0;
        idle(13);
        BUS_RST = 1; Freeze = 0;
        idle(1);
        check("t5_DataOut", DataOut, 0);
        check("t5_TokOut", TokOut, 0);
        check("t5_OVERFLOW", OVERFLOW, 0);
        check("t5_count", dut.fifo_count, 0);
        BUS_RST = 0;
        idle(2);

        // Freeze rising together with a push into an empty FIFO
        HIT_WRITE = 1; HIT_DATA = 27'h0ABCDEF; Freeze = 1;
        idle(1);
        HIT_WRITE = 0;
        idle(3);
        check("t6_frz_cnt", dut.frz_cnt, 0);
        check("t6_tok_frozen", TokOut, 0);
        Read = 1;
        idle(1);
        Read = 0;
        check("t6_read_err", READ_ERR, 1);
        idle(1);
        Freeze = 0;
        idle(3);
        check("t6_tok_released", TokOut, 1);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
